muldiv_sequencer: RTL

//  Multi-cycle controller and datapath for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Owns the HI/LO registers.

---
 rtl/muldiv_sequencer_pkg.sv | 36 +++
 rtl/muldiv_sequencer_if.sv | 19 +
 rtl/muldiv_sequencer_step.sv | 39 +++
 rtl/muldiv_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Optional build macro: MULDIV_FAST_MULT_EN (single-cycle multiply path).
package muldiv_sequencer_pkg;

    localparam int MULDIV_WIDTH        = 32;
    localparam int MULDIV_LATENCY      = 34;
    localparam int MULDIV_FAST_LATENCY = 2;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Two's-complement magnitude; unsigned ops pass the value through untouched.
    function automatic logic [MULDIV_WIDTH-1:0] muldiv_mag(input logic [MULDIV_WIDTH-1:0] v,
                                                           input logic is_signed);
        if (is_signed && v[MULDIV_WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// CPU <-> muldiv sequencer bus: request side (start/op/a/b) and result side (busy/done/hi/lo).
// The CPU side is the master, the sequencer is the slave.
interface muldiv_sequencer_if
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// Multiply: {acc,mq} is shifted right, adding opnd into acc when mq[0] is set.
// Divide:   acc is the partial remainder, mq shifts the dividend out at the top.
module muldiv_sequencer_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mq_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o,
    output logic             qbit_o
);
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic           ge_s;

    // Compute the next accumulator/remainder, shift register and quotient bit.
    always_comb begin
        sum_s     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        shifted_s = {acc_i, mq_i[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, opnd_i});
        acc_o     = acc_i;
        mq_o      = mq_i;
        qbit_o    = 1'b0;
        if (div_mode_i) begin
            // The true difference is below opnd, so WIDTH-bit wraparound is exact.
            acc_o  = ge_s ? (shifted_s[WIDTH-1:0] - opnd_i) : shifted_s[WIDTH-1:0];
            mq_o   = {mq_i[WIDTH-2:0], 1'b0};
            qbit_o = ge_s;
        end else begin
            acc_o  = sum_s[WIDTH:1];
            mq_o   = {sum_s[0], mq_i[WIDTH-1:1]};
            qbit_o = 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO controller owning HI/LO.
// Works on operand magnitudes; signs are re-applied in the FIX state.
// Optional build macro: MULDIV_FAST_MULT_EN (multiplies skip RUN and finish in 2 cycles).
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 5
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam logic [CNT_BITS-1:0] CNT_RELOAD = CNT_BITS'(WIDTH - 1);

    muldiv_state_t       state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]    acc_q, mq_q, opnd_q, hi_q, lo_q;
    logic                div_q, neg_q, rneg_q, dz_q, busy_q, done_q;

    logic                op_signed_s, neg_s;
    logic [WIDTH-1:0]    a_mag_s, b_mag_s;
    logic [WIDTH-1:0]    step_acc_s, step_mq_s, mq_d;
    logic                step_qbit_s;
    logic [2*WIDTH-1:0]  prod_s;
    logic [WIDTH-1:0]    fix_hi_s, fix_lo_s;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0]  fast_prod_s;
`endif

    muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
        .div_mode_i (div_q),
        .acc_i      (acc_q),
        .mq_i       (mq_q),
        .opnd_i     (opnd_q),
        .acc_o      (step_acc_s),
        .mq_o       (step_mq_s),
        .qbit_o     (step_qbit_s)
    );

    // Decode the request: signedness, operand magnitudes and result sign.
    always_comb begin
        if ((bus.op == OP_MULT) || (bus.op == OP_DIV)) begin
            op_signed_s = 1'b1;
        end else begin
            op_signed_s = 1'b0;
        end
        a_mag_s = muldiv_mag(bus.a, op_signed_s);
        b_mag_s = muldiv_mag(bus.b, op_signed_s);
        neg_s   = op_signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef MULDIV_FAST_MULT_EN
        fast_prod_s = {{WIDTH{1'b0}}, a_mag_s} * {{WIDTH{1'b0}}, b_mag_s};
`endif
    end

    // Append the new quotient bit when dividing; multiply keeps the shifted product.
    always_comb begin
        if (div_q) begin
            mq_d = {step_mq_s[WIDTH-1:1], step_qbit_s};
        end else begin
            mq_d = step_mq_s;
        end
    end

    // Sign correction and divide-by-zero override for the FIX write.
    always_comb begin
        prod_s   = {acc_q, mq_q};
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (div_q) begin
            fix_hi_s = rneg_q ? -acc_q : acc_q;
            if (dz_q) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_lo_s = neg_q ? -mq_q : mq_q;
            end
        end else if (neg_q) begin
            {fix_hi_s, fix_lo_s} = -prod_s;
        end else begin
            {fix_hi_s, fix_lo_s} = prod_s;
        end
    end

    // Control FSM with all datapath registers and registered busy/done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
                                {acc_q, mq_q} <= fast_prod_s;
                                state_q       <= FIX;
`else
                                acc_q   <= '0;
                                mq_q    <= b_mag_s;
                                opnd_q  <= a_mag_s;
                                cnt_q   <= CNT_RELOAD;
                                state_q <= RUN;
`endif
                                div_q  <= 1'b0;
                                neg_q  <= neg_s;
                                rneg_q <= 1'b0;
                                dz_q   <= 1'b0;
                                busy_q <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc_q   <= '0;
                                mq_q    <= a_mag_s;
                                opnd_q  <= b_mag_s;
                                cnt_q   <= CNT_RELOAD;
                                div_q   <= 1'b1;
                                neg_q   <= neg_s;
                                rneg_q  <= op_signed_s & bus.a[WIDTH-1];
                                dz_q    <= (bus.b == {WIDTH{1'b0}});
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= step_acc_s;
                    mq_q  <= mq_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    hi_q    <= fix_hi_s;
                    lo_q    <= fix_lo_s;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
